// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one 8-bit ALU between NREQ requesters.
//
// A winner's FunSel/A/B are registered onto the ALU inputs. The arbiter then
// waits LAT clock edges for the ALU to settle, captures OutALU/ZCNO and returns
// them with a one-cycle DONE pulse to the owner. Arbitration also runs on the
// capture edge, so operations can issue back to back.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   REQ                  per-requester request level
//   REQ_FUNSEL/A/B       packed per-requester operation fields
//   GNT                  one-hot pulse: request accepted, operands latched
//   DONE                 one-hot pulse: RES_OUT/RES_ZCNO valid for that requester
//   RES_OUT, RES_ZCNO    captured ALU result and {Z,C,N,O} flags
//   BUSY                 high whenever the FSM is not idle
//   ALU_A/B/FUNSEL       registered ALU inputs
//   ALU_OUT, ALU_ZCNO    ALU outputs
module alu_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [4*NREQ-1:0] REQ_FUNSEL,
  input  logic [8*NREQ-1:0] REQ_A,
  input  logic [8*NREQ-1:0] REQ_B,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   DONE,
  output logic [7:0]        RES_OUT,
  output logic [3:0]        RES_ZCNO,
  output logic              BUSY,
  output logic [7:0]        ALU_A,
  output logic [7:0]        ALU_B,
  output logic [3:0]        ALU_FUNSEL,
  input  logic [7:0]        ALU_OUT,
  input  logic [3:0]        ALU_ZCNO
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(LAT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StCapt} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [7:0]        res_out_q, res_out_d;
  logic [3:0]        res_zcno_q, res_zcno_d;
  logic [7:0]        alu_a_q, alu_a_d;
  logic [7:0]        alu_b_q, alu_b_d;
  logic [3:0]        alu_fs_q, alu_fs_d;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW:0]     cand;
  logic [3:0]        win_fs;
  logic [7:0]        win_a;
  logic [7:0]        win_b;

  // First requester at or above the rr pointer, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_q} + (IdxW + 1)'(k);
      if (cand >= (IdxW + 1)'(NREQ)) begin
        cand = cand - (IdxW + 1)'(NREQ);
      end
      if (!win_found && REQ[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  // Operand mux for the winner.
  always_comb begin
    win_fs = '0;
    win_a  = '0;
    win_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IdxW'(i)) begin
        win_fs = REQ_FUNSEL[4*i +: 4];
        win_a  = REQ_A[8*i +: 8];
        win_b  = REQ_B[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    done_d     = '0;
    res_out_d  = res_out_q;
    res_zcno_d = res_zcno_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_fs_d   = alu_fs_q;

    unique case (state_q)
      StIdle: ;
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        res_out_d       = ALU_OUT;
        res_zcno_d      = ALU_ZCNO;
        done_d[owner_q] = 1'b1;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Arbitration shares the capture edge so operations can run back to back.
    if (state_q != StWait && win_found) begin
      alu_a_d        = win_a;
      alu_b_d        = win_b;
      alu_fs_d       = win_fs;
      owner_d        = win_idx;
      gnt_d[win_idx] = 1'b1;
      rr_d           = (win_idx == IdxW'(NREQ - 1)) ? '0 : win_idx + IdxW'(1);
      cnt_d          = CntW'(LAT);
      state_d        = StWait;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      res_out_q  <= '0;
      res_zcno_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_fs_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      res_out_q  <= res_out_d;
      res_zcno_q <= res_zcno_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_fs_q   <= alu_fs_d;
    end
  end

  assign GNT        = gnt_q;
  assign DONE       = done_q;
  assign RES_OUT    = res_out_q;
  assign RES_ZCNO   = res_zcno_q;
  assign BUSY       = (state_q != StIdle);
  assign ALU_A      = alu_a_q;
  assign ALU_B      = alu_b_q;
  assign ALU_FUNSEL = alu_fs_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (LAT=1 and LAT=2, NREQ=4) share one
// stimulus; each drives its own behavioural clocked ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] fs;
  logic [31:0] a;
  logic [31:0] b;

  logic [3:0]  gnt [2];
  logic [3:0]  done [2];
  logic [3:0]  res_zcno [2];
  logic [3:0]  alu_fs [2];
  logic [3:0]  alu_zcno [2];
  logic [7:0]  res_out [2];
  logic [7:0]  alu_a [2];
  logic [7:0]  alu_b [2];
  logic [7:0]  alu_out [2];
  logic        busy [2];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(4), .LAT(1)) u_dut_lat1 (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_FUNSEL(fs), .REQ_A(a), .REQ_B(b),
    .GNT(gnt[0]), .DONE(done[0]), .RES_OUT(res_out[0]), .RES_ZCNO(res_zcno[0]),
    .BUSY(busy[0]), .ALU_A(alu_a[0]), .ALU_B(alu_b[0]), .ALU_FUNSEL(alu_fs[0]),
    .ALU_OUT(alu_out[0]), .ALU_ZCNO(alu_zcno[0])
  );

  alu_arbiter #(.NREQ(4), .LAT(2)) u_dut_lat2 (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_FUNSEL(fs), .REQ_A(a), .REQ_B(b),
    .GNT(gnt[1]), .DONE(done[1]), .RES_OUT(res_out[1]), .RES_ZCNO(res_zcno[1]),
    .BUSY(busy[1]), .ALU_A(alu_a[1]), .ALU_B(alu_b[1]), .ALU_FUNSEL(alu_fs[1]),
    .ALU_OUT(alu_out[1]), .ALU_ZCNO(alu_zcno[1])
  );

  // Small ALU: 0100 add, 0101 sub (C = borrow), 0111 and, others pass A.
  function automatic logic [11:0] alu_fn(input logic [3:0] f, input logic [7:0] x,
                                         input logic [7:0] y);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       o;
    s = '0; r = x; c = 1'b0; o = 1'b0;
    case (f)
      4'b0100: begin
        s = {1'b0, x} + {1'b0, y}; r = s[7:0]; c = s[8];
        o = (x[7] == y[7]) && (r[7] != x[7]);
      end
      4'b0101: begin
        s = {1'b0, x} - {1'b0, y}; r = s[7:0]; c = s[8];
        o = (x[7] != y[7]) && (r[7] != x[7]);
      end
      4'b0111: r = x & y;
      default: r = x;
    endcase
    return {r, (r == 8'h00), c, r[7], o};
  endfunction

  logic [11:0] p1, p2a, p2b;
  always @(posedge clk) p1 <= alu_fn(alu_fs[0], alu_a[0], alu_b[0]);
  always @(posedge clk) begin
    p2a <= alu_fn(alu_fs[1], alu_a[1], alu_b[1]);
    p2b <= p2a;
  end
  assign alu_out[0]  = p1[11:4];
  assign alu_zcno[0] = p1[3:0];
  assign alu_out[1]  = p2b[11:4];
  assign alu_zcno[1] = p2b[3:0];

  // Reference model: an operation occupies LAT+1 edges; the next accept edge
  // is the one on which its result is returned.
  int          m_edge = 0;
  int          m_next_ok [2];
  int          m_done_edge [2];
  logic [1:0]  m_rr [2];
  logic [1:0]  m_done_idx [2];
  logic [11:0] m_done_val [2];
  logic [3:0]  e_gnt [2];
  logic [3:0]  e_done [2];
  logic [3:0]  e_zcno [2];
  logic [3:0]  e_fs [2];
  logic [7:0]  e_out [2];
  logic [7:0]  e_a [2];
  logic [7:0]  e_b [2];
  logic        e_busy [2];

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic [1:0] w;
      logic [1:0] c;
      bit         found;
      e_gnt[d]  = '0;
      e_done[d] = '0;
      if (rst) begin
        m_rr[d] = '0; m_next_ok[d] = 0; m_done_edge[d] = -1;
        e_out[d] = '0; e_zcno[d] = '0; e_a[d] = '0; e_b[d] = '0; e_fs[d] = '0;
        e_busy[d] = 1'b0;
      end else begin
        if (m_done_edge[d] == m_edge) begin
          e_done[d]      = 4'b0001 << m_done_idx[d];
          e_out[d]       = m_done_val[d][11:4];
          e_zcno[d]      = m_done_val[d][3:0];
          m_done_edge[d] = -1;
        end
        found = 1'b0;
        w     = '0;
        if (m_edge >= m_next_ok[d]) begin
          for (int k = 0; k < 4; k++) begin
            c = m_rr[d] + 2'(k);
            if (!found && req[c]) begin
              found = 1'b1;
              w     = c;
            end
          end
        end
        if (found) begin
          for (int i = 0; i < 4; i++) begin
            if (w == 2'(i)) begin
              e_fs[d] = fs[4*i +: 4];
              e_a[d]  = a[8*i +: 8];
              e_b[d]  = b[8*i +: 8];
            end
          end
          e_gnt[d]       = 4'b0001 << w;
          m_rr[d]        = w + 2'd1;
          m_next_ok[d]   = m_edge + d + 2;
          m_done_edge[d] = m_next_ok[d];
          m_done_idx[d]  = w;
          m_done_val[d]  = alu_fn(e_fs[d], e_a[d], e_b[d]);
        end
        e_busy[d] = (m_edge < m_next_ok[d]);
      end
    end
    m_edge++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; fs = '0; a = '0; b = '0;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if ({gnt[d], done[d], res_out[d], res_zcno[d], alu_a[d], alu_b[d], alu_fs[d],
           busy[d]} !== '0) begin
        n_bad++;
        $display("FAIL reset dut%0d: gnt=%b done=%b out=%h zcno=%b a=%h b=%h fs=%b busy=%b want 0",
                 d, gnt[d], done[d], res_out[d], res_zcno[d], alu_a[d], alu_b[d],
                 alu_fs[d], busy[d]);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if ({gnt[d], busy[d]} !== 5'b0) begin
        n_bad++;
        $display("FAIL idle dut%0d: gnt=%b busy=%b want 0", d, gnt[d], busy[d]);
      end
    end
  endtask

  task automatic test_single();
    // Subtract 5-5 from requester 0.
    req = 4'b0001; fs = 16'h0005; a = 32'h05; b = 32'h05;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if ({gnt[d], busy[d]} !== 5'b0001_1) begin
        n_bad++;
        $display("FAIL t1_gnt dut%0d: gnt=%b busy=%b want 0001 1", d, gnt[d], busy[d]);
      end
    end
    req = '0;
    tick();
    n_total++;
    if ({gnt[0], done[0], busy[0]} !== 9'b0000_0000_1) begin
      n_bad++;
      $display("FAIL t1_wait: gnt=%b done=%b busy=%b want 0000 0000 1", gnt[0], done[0], busy[0]);
    end
    tick();
    n_total++;
    if ({done[0], res_out[0], res_zcno[0], busy[0]} !== {4'b0001, 8'h00, 4'b1000, 1'b0}) begin
      n_bad++;
      $display("FAIL t1_done: done=%b out=%h zcno=%b busy=%b want 0001 00 1000 0",
               done[0], res_out[0], res_zcno[0], busy[0]);
    end
    n_total++;
    if ({done[1], alu_a[1], alu_b[1], alu_fs[1], busy[1]} !== {4'b0, 8'h05, 8'h05, 4'b0101, 1'b1})
    begin
      n_bad++;
      $display("FAIL t6_hold: done=%b a=%h b=%h fs=%b busy=%b want 0000 05 05 0101 1",
               done[1], alu_a[1], alu_b[1], alu_fs[1], busy[1]);
    end
    tick();
    n_total++;
    if ({done[1], res_out[1], res_zcno[1], busy[1], done[0]} !==
        {4'b0001, 8'h00, 4'b1000, 1'b0, 4'b0}) begin
      n_bad++;
      $display("FAIL t6_done: done=%b out=%h zcno=%b busy=%b done0=%b want 0001 00 1000 0 0000",
               done[1], res_out[1], res_zcno[1], busy[1], done[0]);
    end
    // Add 7F+01: signed overflow into negative.
    req = 4'b0001; fs = 16'h0004; a = 32'h7F; b = 32'h01;
    tick();
    n_total++;
    if (gnt[0] !== 4'b0001) begin
      n_bad++;
      $display("FAIL t2_gnt: gnt=%b want 0001", gnt[0]);
    end
    req = '0; a = 32'hFF; b = 32'hFF; // late operand change must not matter
    tick();
    tick();
    n_total++;
    if ({done[0], res_out[0], res_zcno[0]} !== {4'b0001, 8'h80, 4'b0011}) begin
      n_bad++;
      $display("FAIL t2_done: done=%b out=%h zcno=%b want 0001 80 0011",
               done[0], res_out[0], res_zcno[0]);
    end
    tick();
    n_total++;
    if ({done[1], res_out[1], res_zcno[1], done[0], res_out[0]} !==
        {4'b0001, 8'h80, 4'b0011, 4'b0, 8'h80}) begin
      n_bad++;
      $display("FAIL t2_lat2: done1=%b out1=%h zcno1=%b done0=%b out0=%h want 0001 80 0011 0000 80",
               done[1], res_out[1], res_zcno[1], done[0], res_out[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ra [4];
    logic [7:0] rb [4];
    logic [3:0] eg;
    logic [3:0] ed;
    logic [7:0] er;
    int         j;
    rst = 1'b1; req = '0; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra[i] = 8'($urandom);
      rb[i] = 8'($urandom);
    end
    a = {ra[3], ra[2], ra[1], ra[0]};
    b = {rb[3], rb[2], rb[1], rb[0]};
    fs = 16'h7777; req = 4'b1111;
    for (int n = 0; n <= 8; n++) begin
      tick();
      eg = (n % 2 == 0) ? 4'b0001 << ((n / 2) % 4) : 4'b0;
      ed = (n >= 2 && n % 2 == 0) ? 4'b0001 << ((n / 2 - 1) % 4) : 4'b0;
      n_total++;
      if ({gnt[0], done[0]} !== {eg, ed}) begin
        n_bad++;
        $display("FAIL rr_order n=%0d: gnt=%b done=%b want %b %b", n, gnt[0], done[0], eg, ed);
      end
      if (ed != 4'b0) begin
        j  = (n / 2 - 1) % 4;
        er = ra[j] & rb[j];
        n_total++;
        if ({res_out[0], res_zcno[0]} !== {er, er == 8'h00, 1'b0, er[7], 1'b0}) begin
          n_bad++;
          $display("FAIL rr_result req%0d: out=%h zcno=%b want %h", j, res_out[0], res_zcno[0], er);
        end
      end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] e0;
    logic [3:0] e1;
    rst = 1'b1; req = '0; tick(); rst = 1'b0;
    fs = 16'h4444; a = $urandom; b = $urandom; req = 4'b0101;
    for (int n = 0; n < 12; n++) begin
      tick();
      e0 = (n % 2 == 0) ? (((n / 2) % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0;
      e1 = (n % 3 == 0) ? (((n / 3) % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0;
      n_total++;
      if ({gnt[0], gnt[1]} !== {e0, e1}) begin
        n_bad++;
        $display("FAIL fair n=%0d: gnt0=%b gnt1=%b want %b %b", n, gnt[0], gnt[1], e0, e1);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; req = '0; tick(); rst = 1'b0;
    req = 4'b0001; fs = 16'h0004; a = 32'h11; b = 32'h22;
    tick();
    req = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if ({gnt[d], done[d], res_out[d], res_zcno[d], alu_a[d], alu_b[d], alu_fs[d],
           busy[d]} !== '0) begin
        n_bad++;
        $display("FAIL midrst dut%0d: gnt=%b done=%b out=%h a=%h busy=%b want 0",
                 d, gnt[d], done[d], res_out[d], alu_a[d], busy[d]);
      end
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_total++;
        if ({done[d], busy[d]} !== 5'b0) begin
          n_bad++;
          $display("FAIL midrst_nodone dut%0d n=%0d: done=%b busy=%b want 0",
                   d, n, done[d], busy[d]);
        end
      end
    end
    req = 4'b1001;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (gnt[d] !== 4'b0001) begin
        n_bad++;
        $display("FAIL midrst_first dut%0d: gnt=%b want 0001", d, gnt[d]);
      end
    end
    req = '0;
  endtask

  task automatic test_random();
    rst = 1'b1; req = '0; tick(); rst = 1'b0;
    for (int n = 0; n < 800; n++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_total++;
        if ({gnt[d], done[d], busy[d]} !== {e_gnt[d], e_done[d], e_busy[d]}) begin
          n_bad++;
          $display("FAIL rnd_ctl dut%0d n=%0d: gnt=%b done=%b busy=%b want %b %b %b", d, n,
                   gnt[d], done[d], busy[d], e_gnt[d], e_done[d], e_busy[d]);
        end
        n_total++;
        if ({res_out[d], res_zcno[d], alu_a[d], alu_b[d], alu_fs[d]} !==
            {e_out[d], e_zcno[d], e_a[d], e_b[d], e_fs[d]}) begin
          n_bad++;
          $display("FAIL rnd_data dut%0d n=%0d: out=%h zcno=%b a=%h b=%h fs=%b want %h %b %h %h %b",
                   d, n, res_out[d], res_zcno[d], alu_a[d], alu_b[d], alu_fs[d],
                   e_out[d], e_zcno[d], e_a[d], e_b[d], e_fs[d]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            case ($urandom_range(0, 3))
              0:       fs[4*i +: 4] = 4'b0100;
              1:       fs[4*i +: 4] = 4'b0101;
              2:       fs[4*i +: 4] = 4'b0111;
              default: fs[4*i +: 4] = 4'($urandom);
            endcase
            a[8*i +: 8] = 8'($urandom);
            b[8*i +: 8] = 8'($urandom);
          end
        end else if (gnt[0][i] || gnt[1][i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else a[8*i +: 8] = 8'($urandom);
        end else if ($urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
